conv2d_engine: RTL and testbench

CONV2D_ENGINE -- requirements
Module: conv2d_engine

---
 rtl/conv_pkg.sv | 36 +++
 rtl/conv_mac.sv | 37 +++
 rtl/conv2d_engine.sv | 179 +++++++++++++++++
 tb/tb_conv2d_engine.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding and result helpers for conv2d_engine.
// CONV2D_SAT_EN: when defined, results saturate to OUT_W instead of wrapping.
package conv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, DONE} state_t;

  localparam int unsigned RES_MAX_W = 64;

  function automatic int unsigned win_count(input int unsigned img_n, input int unsigned k);
    return (img_n - k + 1) * (img_n - k + 1);
  endfunction

  // Returns the OUT_W-bit result sign-extended to RES_MAX_W bits.
  function automatic logic signed [RES_MAX_W-1:0] fit_result(
    input logic signed [RES_MAX_W-1:0] v,
    input int unsigned                 out_w
  );
`ifdef CONV2D_SAT_EN
    logic signed [RES_MAX_W-1:0] hi;
    logic signed [RES_MAX_W-1:0] lo;
    hi           = '0;
    hi[out_w-1]  = 1'b1;
    hi           = hi - RES_MAX_W'(1);
    lo           = ~hi;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
`else
    return (v <<< (RES_MAX_W - out_w)) >>> (RES_MAX_W - out_w);
`endif
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate; clr restarts the sum with the current product.
module conv_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] pix,
  input  logic signed [DATA_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    acc_q;

  always_comb begin
    prod  = (2*DATA_W)'(pix) * (2*DATA_W)'(coef);
    acc_d = acc_q;
    if (en) begin
      acc_d = (clr ? '0 : acc_q) + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv2d_engine.sv
// Frame-based 2D convolution: load IMG_N x IMG_N pixels, emit one result per KxK window.
// Build option CONV2D_SAT_EN selects saturating (vs wrapping) result narrowing.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_N  = 3,
  parameter int K      = 2,
  parameter int OUT_W  = 2*DATA_W
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     coef_we,
  input  logic [((K*K > 1) ? $clog2(K*K) : 1)-1:0] coef_addr,
  input  logic signed [DATA_W-1:0]                 coef_data,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic signed [DATA_W-1:0]                 in_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic signed [OUT_W-1:0]                  out_data,
  output logic                                     busy,
  output logic                                     done
);

  localparam int NPIX  = IMG_N * IMG_N;
  localparam int NTAP  = K * K;
  localparam int NWIN  = win_count(IMG_N, K);
  localparam int PIX_W = $clog2(NPIX);
  localparam int CW    = $clog2(IMG_N);
  localparam int WC_W  = (NWIN > 1) ? $clog2(NWIN) : 1;
  localparam int TAP_W = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int ACC_W = 2*DATA_W + $clog2(NTAP);

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]     r_q, r_d, c_q, c_d, ki_q, ki_d, kj_q, kj_d;
  logic [WC_W-1:0]   win_q, win_d;

  logic signed [DATA_W-1:0] pix_mem_q  [NPIX];
  logic signed [DATA_W-1:0] coef_mem_q [NTAP];

  logic                     pix_we, mac_en, mac_clr;
  logic [PIX_W-1:0]         rd_idx;
  logic [TAP_W-1:0]         tap_idx;
  logic signed [ACC_W-1:0]  acc;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    r_d       = r_q;
    c_d       = c_q;
    ki_d      = ki_q;
    kj_d      = kj_q;
    win_d     = win_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    pix_we    = 1'b0;
    mac_en    = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          pix_cnt_d = '0;
          r_d       = '0;
          c_d       = '0;
          ki_d      = '0;
          kj_d      = '0;
          win_d     = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pix_we    = 1'b1;
          pix_cnt_d = pix_cnt_q + PIX_W'(1);
          if (pix_cnt_q == PIX_W'(NPIX - 1)) state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (kj_q == CW'(K - 1)) begin
          kj_d = '0;
          if (ki_q == CW'(K - 1)) begin
            ki_d    = '0;
            state_d = OUT;
          end else begin
            ki_d = ki_q + CW'(1);
          end
        end else begin
          kj_d = kj_q + CW'(1);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (win_q == WC_W'(NWIN - 1)) begin
            state_d = DONE;
          end else begin
            state_d = MAC;
            win_d   = win_q + WC_W'(1);
            if (c_q == CW'(IMG_N - K)) begin
              c_d = '0;
              r_d = r_q + CW'(1);
            end else begin
              c_d = c_q + CW'(1);
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      r_q       <= '0;
      c_q       <= '0;
      ki_q      <= '0;
      kj_q      <= '0;
      win_q     <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      r_q       <= r_d;
      c_q       <= c_d;
      ki_q      <= ki_d;
      kj_q      <= kj_d;
      win_q     <= win_d;
    end
  end

  // Kernel is frozen once a frame starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAP; i++) coef_mem_q[i] <= '0;
    end else if (state_q == IDLE && coef_we && int'(coef_addr) < NTAP) begin
      coef_mem_q[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_we) pix_mem_q[pix_cnt_q] <= in_data;
  end

  always_comb begin
    rd_idx  = PIX_W'((int'(r_q) + int'(ki_q)) * IMG_N + int'(c_q) + int'(kj_q));
    tap_idx = TAP_W'(int'(ki_q) * K + int'(kj_q));
    mac_clr = (ki_q == '0) && (kj_q == '0);
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (mac_en),
    .pix   (pix_mem_q[rd_idx]),
    .coef  (coef_mem_q[tap_idx]),
    .acc   (acc)
  );

  always_comb begin
    out_data = '0;
    if (state_q == OUT) out_data = OUT_W'(fit_result(RES_MAX_W'(acc), OUT_W));
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// Directed bench for conv2d_engine: 3x3/K=2 frames (table driven) and a 4x4/K=1 frame.
module tb_conv2d_engine;

`ifdef CONV2D_SAT_EN
  localparam int EXP_MAX = 32767;
  localparam int EXP_MIN = -32768;
`else
  localparam int EXP_MAX = -1020;
  localparam int EXP_MIN = 512;
`endif

  typedef struct packed {
    logic [8:0][7:0]  pix;
    logic [3:0][7:0]  coef;
    logic [3:0][15:0] exp;
    int               stall;
    logic             inject;
    logic             wr_coef;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              a_start = 0, a_coef_we = 0, a_in_valid = 0, a_out_ready = 0;
  logic [1:0]        a_coef_addr = '0;
  logic signed [7:0] a_coef_data = '0, a_in_data = '0;
  logic              a_in_ready, a_out_valid, a_busy, a_done;
  logic signed [15:0] a_out_data;

  logic              b_start = 0, b_coef_we = 0, b_in_valid = 0, b_out_ready = 0;
  logic [0:0]        b_coef_addr = '0;
  logic signed [7:0] b_coef_data = '0, b_in_data = '0;
  logic              b_in_ready, b_out_valid, b_busy, b_done;
  logic signed [15:0] b_out_data;

  conv2d_engine dut_a (
    .clk(clk), .reset(rst), .start(a_start), .coef_we(a_coef_we), .coef_addr(a_coef_addr),
    .coef_data(a_coef_data), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .busy(a_busy), .done(a_done)
  );

  conv2d_engine #(.IMG_N(4), .K(1)) dut_b (
    .clk(clk), .reset(rst), .start(b_start), .coef_we(b_coef_we), .coef_addr(b_coef_addr),
    .coef_data(b_coef_data), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .busy(b_busy), .done(b_done)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  int pix_seq[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
  int pix_mix[9] = '{-5, 3, 0, 7, -128, 2, 1, 1, -1};
  int pix_max[9] = '{default: 127};
  int pix_min[9] = '{default: -128};
  int c_1010[4]  = '{1, 0, 1, 0};
  int c_mix[4]   = '{2, -1, 0, 3};
  int c_max[4]   = '{default: 127};
  int e_seq[4]   = '{5, 7, 11, 13};
  int e_mix[4]   = '{-397, 12, 145, -261};
  int e_max[4]   = '{default: EXP_MAX};
  int e_min[4]   = '{default: EXP_MIN};
  int e_zero[4]  = '{default: 0};

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int p[9], input int c[4], input int e[4],
                              input int st, input logic inj, input logic wr);
    vec_t v;
    for (int i = 0; i < 9; i++) v.pix[i] = 8'(p[i]);
    for (int i = 0; i < 4; i++) begin
      v.coef[i] = 8'(c[i]);
      v.exp[i]  = 16'(e[i]);
    end
    v.stall   = st;
    v.inject  = inj;
    v.wr_coef = wr;
    return v;
  endfunction

  // Coefficients (last write shares the start cycle), then pixels up to n_pix.
  task automatic a_begin(input vec_t v, input int n_pix);
    int k;
    int guard;
    if (v.wr_coef) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        a_coef_we = 1; a_coef_addr = 2'(i); a_coef_data = v.coef[i]; a_start = (i == 3);
      end
    end else begin
      @(negedge clk);
      a_start = 1;
    end
    @(negedge clk);
    a_start = 0; a_coef_we = 0;
    chk("busy_after_start", int'(a_busy), 1);
    k = 0; guard = 0;
    while (k < n_pix && guard < 100) begin
      a_in_valid = 1; a_in_data = v.pix[k];
      if (a_in_ready) k++;
      @(negedge clk);
      guard++;
    end
    a_in_valid = 0;
    if (guard >= 100) chk("load_timeout", k, n_pix);
  endtask

  task automatic run_a(input vec_t v, input int id);
    int j, cyc, last_t;
    a_begin(v, 9);
    if (v.inject) begin
      a_start = 1; a_coef_we = 1; a_coef_addr = 2'd1; a_coef_data = 8'sd50;
      @(negedge clk);
      a_start = 0; a_coef_we = 0;
    end
    j = 0; cyc = 0; last_t = -1;
    while (j < 4 && cyc < 200) begin
      a_out_ready = (v.stall == 0) || (cyc % 3 == 2);
      if (a_out_valid) begin
        chk($sformatf("v%0d_out%0d", id, j), int'(a_out_data), int'($signed(v.exp[j])));
        if (a_out_ready) begin
          if (v.stall == 0 && last_t >= 0) chk($sformatf("v%0d_interval", id), cyc - last_t, 5);
          last_t = cyc;
          j++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    a_out_ready = 0;
    if (cyc >= 200) chk($sformatf("v%0d_out_timeout", id), j, 4);
    chk($sformatf("v%0d_done_pulse", id), int'(a_done), 1);
    @(negedge clk);
    chk($sformatf("v%0d_done_clear", id), int'(a_done), 0);
    chk($sformatf("v%0d_busy_idle", id), int'(a_busy), 0);
  endtask

  task automatic run_b();
    int k, j, cyc;
    @(negedge clk);
    b_coef_we = 1; b_coef_addr = 1'b0; b_coef_data = 8'sd1; b_start = 1;
    @(negedge clk);
    b_coef_we = 0; b_start = 0;
    k = 0; cyc = 0;
    while (k < 16 && cyc < 100) begin
      b_in_valid = 1; b_in_data = 8'(k);
      if (b_in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    b_in_valid = 0;
    if (cyc >= 100) chk("b_load_timeout", k, 16);
    j = 0; cyc = 0; b_out_ready = 1;
    while (j < 16 && cyc < 200) begin
      if (b_out_valid) begin
        chk($sformatf("b_out%0d", j), int'(b_out_data), j);
        j++;
      end
      @(negedge clk);
      cyc++;
    end
    b_out_ready = 0;
    if (cyc >= 200) chk("b_out_timeout", j, 16);
    chk("b_done_pulse", int'(b_done), 1);
    @(negedge clk);
    chk("b_busy_idle", int'(b_busy), 0);
  endtask

  initial begin
    vecs[0] = mk(pix_seq, c_1010, e_seq, 0, 1'b0, 1'b1);
    vecs[1] = mk(pix_seq, c_1010, e_seq, 1, 1'b0, 1'b1);
    vecs[2] = mk(pix_seq, c_1010, e_seq, 0, 1'b1, 1'b1);
    vecs[3] = mk(pix_mix, c_mix, e_mix, 0, 1'b0, 1'b1);
    vecs[4] = mk(pix_max, c_max, e_max, 0, 1'b0, 1'b1);
    vecs[5] = mk(pix_min, c_max, e_min, 0, 1'b0, 1'b1);

    #1;
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_done", int'(a_done), 0);
    chk("rst_in_ready", int'(a_in_ready), 0);
    chk("rst_out_valid", int'(a_out_valid), 0);
    chk("rst_out_data", int'(a_out_data), 0);
    repeat (2) @(negedge clk);
    rst = 0;

    for (int i = 0; i < 6; i++) run_a(vecs[i], i);

    run_b();

    // Reset mid-LOAD, then a frame with no coefficient writes must yield zeros.
    a_begin(vecs[0], 4);
    chk("mid_load_ready", int'(a_in_ready), 1);
    rst = 1;
    #1;
    chk("mid_rst_busy", int'(a_busy), 0);
    chk("mid_rst_in_ready", int'(a_in_ready), 0);
    chk("mid_rst_out_valid", int'(a_out_valid), 0);
    chk("mid_rst_done", int'(a_done), 0);
    @(negedge clk);
    rst = 0;
    run_a(mk(pix_seq, c_1010, e_zero, 0, 1'b0, 1'b0), 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
